// File: rtl/nib_to_byte_fifo_ctrl_pkg.sv
// Shared sizes, types and helpers for the nibble-in / byte-out FIFO controller.
package nib_fifo_pkg;

  localparam int RAM_NIB_DEPTH  = 1024;
  localparam int RAM_BYTE_DEPTH = 512;
  localparam int NIB_ADDR_W     = $clog2(RAM_NIB_DEPTH);
  localparam int BYTE_ADDR_W    = $clog2(RAM_BYTE_DEPTH);
  localparam int COUNT_W        = NIB_ADDR_W + 1;

  typedef logic [NIB_ADDR_W-1:0]  nib_addr_t;
  typedef logic [BYTE_ADDR_W-1:0] byte_addr_t;
  typedef logic [COUNT_W-1:0]     nib_count_t;

  localparam nib_count_t FULL_COUNT = nib_count_t'(RAM_NIB_DEPTH);

  // Occupancy of the 2-entry output skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] skid_level(skid_state_e s);
    case (s)
      SKID_ONE: return 2'd1;
      SKID_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nib_to_byte_fifo_ctrl_if.sv
// Push, pop, status and block-RAM port bundle of the nibble-to-byte FIFO controller.
interface nib_to_byte_fifo_ctrl_if;
  import nib_fifo_pkg::*;

  logic [3:0] nib_data;
  logic       nib_valid;
  logic       nib_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  nib_count_t nib_count;
  logic       almost_full;
  logic       almost_empty;
  logic       half_byte;
  nib_addr_t  ram_addra;
  logic [3:0] ram_dia;
  logic       ram_ena;
  logic       ram_wea;
  byte_addr_t ram_addrb;
  logic       ram_enb;
  logic       ram_web;
  logic       ram_rsta;
  logic       ram_rstb;
  logic [7:0] ram_dob;

  // The controller side.
  modport slave (
    input  nib_data, nib_valid, byte_ready, ram_dob,
    output nib_ready, byte_data, byte_valid, nib_count, almost_full, almost_empty, half_byte,
    output ram_addra, ram_dia, ram_ena, ram_wea, ram_addrb, ram_enb, ram_web, ram_rsta, ram_rstb
  );

  // The surrounding source, consumer and RAM.
  modport master (
    output nib_data, nib_valid, byte_ready, ram_dob,
    input  nib_ready, byte_data, byte_valid, nib_count, almost_full, almost_empty, half_byte,
    input  ram_addra, ram_dia, ram_ena, ram_wea, ram_addrb, ram_enb, ram_web, ram_rsta, ram_rstb
  );

endinterface

// File: rtl/nib_to_byte_fifo_ctrl_skid2.sv
// Two-entry output skid buffer: captures RAM read data and holds it until the consumer takes it.
module nib_fifo_skid2
  import nib_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] level
);

  skid_state_e state_q, state_d;
  logic [7:0]  head_q, head_d;
  logic [7:0]  tail_q, tail_d;

  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_q;
  assign level     = skid_level(state_q);

  // Next occupancy and entry contents; the head only moves when the consumer takes it.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (clear) begin
      state_d = SKID_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (load) begin
            state_d = SKID_ONE;
            head_d  = load_data;
          end
        end
        SKID_ONE: begin
          if (load && out_ready) begin
            head_d = load_data;
          end else if (load) begin
            state_d = SKID_TWO;
            tail_d  = load_data;
          end else if (out_ready) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (out_ready) begin
            head_d = tail_q;
            if (load) begin
              tail_d = load_data;
            end else begin
              state_d = SKID_ONE;
            end
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/nib_to_byte_fifo_ctrl.sv
// Nibble-write / byte-read FIFO controller for a 1024x4 / 512x8 dual-port block RAM.
module nib_to_byte_fifo_ctrl
  import nib_fifo_pkg::*;
#(
  parameter int AF_LEVEL = 1000,
  parameter int AE_LEVEL = 2
) (
  input logic clk,
  input logic rst,
  input logic flush,
  nib_to_byte_fifo_ctrl_if.slave bus
);

  logic       clear;
  logic       nib_ready;
  logic       push;
  logic       pop;
  logic       fetch;
  logic [2:0] pending;
  logic       skid_valid;
  logic [7:0] skid_data;
  logic [1:0] skid_fill;

  nib_count_t count_q, count_d;
  nib_addr_t  wr_ptr_q, wr_ptr_d;
  byte_addr_t rd_ptr_q, rd_ptr_d;
  logic       in_flight_q, in_flight_d;

  assign clear     = rst | flush;
  assign nib_ready = !clear && (count_q != FULL_COUNT);
  assign push      = bus.nib_valid && nib_ready;
  assign pop       = skid_valid && bus.byte_ready && !clear;
  // Bytes already owed to the skid buffer after this cycle's pop; fetch only while there is room.
  assign pending   = {1'b0, skid_fill} + {2'b00, in_flight_q} - {2'b00, pop};
  assign fetch     = !clear && (count_q >= nib_count_t'(2)) && (pending < 3'd2);

  // Pointer, occupancy and in-flight bookkeeping for push and fetch.
  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_flight_d = fetch;
    if (clear) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + nib_addr_t'(1);
        count_d  = count_d + nib_count_t'(1);
      end
      if (fetch) begin
        rd_ptr_d = rd_ptr_q + byte_addr_t'(1);
        count_d  = count_d - nib_count_t'(2);
      end
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
    end
  end

  nib_fifo_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (in_flight_q && !clear),
    .load_data (bus.ram_dob),
    .out_ready (bus.byte_ready && !clear),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .level     (skid_fill)
  );

  assign bus.nib_ready    = nib_ready;
  assign bus.byte_valid   = skid_valid;
  assign bus.byte_data    = skid_data;
  assign bus.nib_count    = count_q;
  assign bus.almost_full  = (count_q >= nib_count_t'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= nib_count_t'(AE_LEVEL));
  assign bus.half_byte    = wr_ptr_q[0];
  assign bus.ram_addra    = wr_ptr_q;
  assign bus.ram_dia      = bus.nib_data;
  assign bus.ram_ena      = push;
  assign bus.ram_wea      = push;
  assign bus.ram_addrb    = rd_ptr_q;
  assign bus.ram_enb      = fetch;
  assign bus.ram_web      = 1'b0;
  assign bus.ram_rsta     = 1'b0;
  assign bus.ram_rstb     = 1'b0;

endmodule

// File: tb/tb_nib_to_byte_fifo_ctrl.sv
// Bench for nib_to_byte_fifo_ctrl with a 4/8 dual-port RAM model and a nibble-queue reference.
module tb_nib_to_byte_fifo_ctrl;

  logic clk;
  logic rst;
  logic flush;

  nib_to_byte_fifo_ctrl_if bus ();

  nib_to_byte_fifo_ctrl #(
    .AF_LEVEL (1000),
    .AE_LEVEL (2)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int bytes_seen = 0;
  int cyc = 0;

  logic [3:0] exp_nibs[$];
  logic       have_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [3:0] ram_mem [0:1023];
  logic [7:0] ram_dob_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAM model: nibble writes on port A, byte reads of nibble pair 2k/2k+1 on port B.
  always @(posedge clk) begin
    if (bus.ram_ena && bus.ram_wea) ram_mem[bus.ram_addra] <= bus.ram_dia;
    if (bus.ram_enb && !bus.ram_web)
      ram_dob_q <= {ram_mem[{bus.ram_addrb, 1'b1}], ram_mem[{bus.ram_addrb, 1'b0}]};
  end
  assign bus.ram_dob = ram_dob_q;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: every accepted nibble joins a queue; every byte taken must be the oldest two, low first.
  always @(negedge clk) begin
    logic [31:0] exp_byte;
    if (rst || flush) begin
      exp_nibs.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        checkOutput("hold_valid", 32'(bus.byte_valid), 32'd1);
        checkOutput("hold_data", 32'(bus.byte_data), 32'(prev_data));
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (exp_nibs.size() >= 2) begin
          exp_byte = {24'd0, exp_nibs[1], exp_nibs[0]};
          void'(exp_nibs.pop_front());
          void'(exp_nibs.pop_front());
        end else begin
          exp_byte = 32'h1FF;
        end
        checkOutput("pop_data", 32'(bus.byte_data), exp_byte);
        bytes_seen++;
      end
      have_prev = bus.byte_valid && !bus.byte_ready;
      prev_data = bus.byte_data;
      if (bus.nib_valid && bus.nib_ready) exp_nibs.push_back(bus.nib_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one nibble and hold it until accepted (bounded), leaving valid low afterwards.
  task automatic applyStimulus(input logic [3:0] nib);
    logic ok;
    ok = 1'b0;
    bus.nib_data  = nib;
    bus.nib_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.nib_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.nib_valid = 1'b0;
    checkOutput("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic waitByte(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.byte_valid) break;
      tick();
    end
    checkOutput(tag, 32'(bus.byte_valid), 32'd1);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    int seen_valid;
    int left;
    rst = 1'b1;
    flush = 1'b0;
    bus.nib_data = 4'h0;
    bus.nib_valid = 1'b0;
    bus.byte_ready = 1'b0;
    runTicks(3);

    // Reset: no handshakes while reset is held, then the documented idle state.
    bus.nib_valid = 1'b1;
    tick();
    checkOutput("rst_nib_ready", 32'(bus.nib_ready), 32'd0);
    checkOutput("rst_ram_ena", 32'(bus.ram_ena), 32'd0);
    checkOutput("rst_ram_enb", 32'(bus.ram_enb), 32'd0);
    bus.nib_valid = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("rst_count", 32'(bus.nib_count), 32'd0);
    checkOutput("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
    checkOutput("rst_byte_data", 32'(bus.byte_data), 32'd0);
    checkOutput("rst_half_byte", 32'(bus.half_byte), 32'd0);
    checkOutput("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    checkOutput("rst_almost_full", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_nib_ready_idle", 32'(bus.nib_ready), 32'd1);
    checkOutput("tied_ram_web", 32'({bus.ram_web, bus.ram_rsta, bus.ram_rstb}), 32'd0);

    // 1: 3 then A gives 8'hA3, visible two edges after A is accepted.
    $display("[TB] step 1: single byte latency");
    bus.byte_ready = 1'b1;
    applyStimulus(4'h3);
    applyStimulus(4'hA);
    checkOutput("t1_count_2", 32'(bus.nib_count), 32'd2);
    checkOutput("t1_fetch", 32'(bus.ram_enb), 32'd1);
    checkOutput("t1_valid_early0", 32'(bus.byte_valid), 32'd0);
    tick();
    checkOutput("t1_valid_early1", 32'(bus.byte_valid), 32'd0);
    tick();
    checkOutput("t1_valid_rise", 32'(bus.byte_valid), 32'd1);
    checkOutput("t1_data", 32'(bus.byte_data), 32'hA3);
    tick();
    checkOutput("t1_valid_gone", 32'(bus.byte_valid), 32'd0);
    checkOutput("t1_count_0", 32'(bus.nib_count), 32'd0);

    // 2: a lone nibble stays stored until its partner arrives.
    $display("[TB] step 2: half byte");
    applyStimulus(4'h5);
    checkOutput("t2_half_byte", 32'(bus.half_byte), 32'd1);
    checkOutput("t2_count_1", 32'(bus.nib_count), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.byte_valid) seen_valid++;
      tick();
    end
    checkOutput("t2_no_byte", 32'(seen_valid), 32'd0);
    applyStimulus(4'hC);
    waitByte("t2_byte_timeout", 6);
    checkOutput("t2_data", 32'(bus.byte_data), 32'hC5);
    runTicks(2);
    checkOutput("t2_half_clear", 32'(bus.half_byte), 32'd0);
    checkOutput("t2_count_0", 32'(bus.nib_count), 32'd0);

    // 3: consumer stalled: fill RAM plus skid, refuse further pushes, then drain in order.
    $display("[TB] step 3: fill and drain");
    bus.byte_ready = 1'b0;
    base = bytes_seen;
    for (int i = 0; i < 1028; i++) applyStimulus(4'(i));
    checkOutput("t3_count_full", 32'(bus.nib_count), 32'd1024);
    checkOutput("t3_nib_ready_low", 32'(bus.nib_ready), 32'd0);
    checkOutput("t3_almost_full", 32'(bus.almost_full), 32'd1);
    checkOutput("t3_almost_empty", 32'(bus.almost_empty), 32'd0);
    checkOutput("t3_head", 32'(bus.byte_data), 32'h10);
    bus.nib_data = 4'hF;
    bus.nib_valid = 1'b1;
    runTicks(3);
    bus.nib_valid = 1'b0;
    checkOutput("t3_count_held", 32'(bus.nib_count), 32'd1024);
    bus.byte_ready = 1'b1;
    runTicks(600);
    checkOutput("t3_bytes", 32'(bytes_seen - base), 32'd514);
    checkOutput("t3_count_0", 32'(bus.nib_count), 32'd0);
    checkOutput("t3_almost_empty_end", 32'(bus.almost_empty), 32'd1);

    // 4: continuous streaming with pointer wrap, one nibble accepted every cycle.
    $display("[TB] step 4: streaming");
    base = bytes_seen;
    left = cyc;
    for (int i = 0; i < 3000; i++) applyStimulus(4'($urandom));
    checkOutput("t4_cycles", 32'(cyc - left), 32'd3000);
    runTicks(10);
    checkOutput("t4_bytes", 32'(bytes_seen - base), 32'd1500);
    checkOutput("t4_count_0", 32'(bus.nib_count), 32'd0);

    // 5: random push and random consumer stalls.
    $display("[TB] step 5: random stalls");
    for (int i = 0; i < 800; i++) begin
      bus.byte_ready = 1'($urandom_range(0, 1));
      bus.nib_valid  = ($urandom_range(0, 3) != 0);
      bus.nib_data   = 4'($urandom);
      tick();
    end
    bus.nib_valid = 1'b0;
    bus.byte_ready = 1'b1;
    runTicks(1200);
    left = exp_nibs.size();
    checkOutput("t5_count_model", 32'(bus.nib_count), 32'(left));
    checkOutput("t5_half_model", 32'(bus.half_byte), 32'(left % 2));
    checkOutput("t5_drained", 32'(bus.byte_valid), 32'd0);
    if (left % 2 == 1) begin
      applyStimulus(4'($urandom));
      runTicks(6);
    end
    checkOutput("t5_count_0", 32'(bus.nib_count), 32'd0);

    // 6: flush with 37 stored, an odd write pointer and a fetch in flight.
    $display("[TB] step 6: flush");
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 43; i++) applyStimulus(4'($urandom));
    runTicks(4);
    checkOutput("t6_count_39", 32'(bus.nib_count), 32'd39);
    checkOutput("t6_half_pre", 32'(bus.half_byte), 32'd1);
    bus.byte_ready = 1'b1;
    tick();
    checkOutput("t6_count_37", 32'(bus.nib_count), 32'd37);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("t6_count_0", 32'(bus.nib_count), 32'd0);
    checkOutput("t6_valid_0", 32'(bus.byte_valid), 32'd0);
    checkOutput("t6_half_0", 32'(bus.half_byte), 32'd0);
    tick();
    checkOutput("t6_inflight_dropped", 32'(bus.byte_valid), 32'd0);
    base = bytes_seen;
    applyStimulus(4'h7);
    applyStimulus(4'h7);
    waitByte("t6_byte_timeout", 6);
    checkOutput("t6_data", 32'(bus.byte_data), 32'h77);
    runTicks(4);
    checkOutput("t6_one_byte", 32'(bytes_seen - base), 32'd1);
    checkOutput("t6_count_end", 32'(bus.nib_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
